// File: rtl/fpu_mem_pkg.sv
// Shared types and constants for the FPU scratch-memory arbiter and its requesters.
package fpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } arb_state_t;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;
    localparam int unsigned PORT_C = 2;
    localparam int unsigned PORT_D = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational grant select: round-robin after last_grant, or lowest-index-first when
// MEM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Scan downwards so the lowest eligible index is written last and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                valid     = 1'b1;
            end
        end
    end
`else
    // Scan offsets from farthest to nearest so the port just after last_grant wins.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                valid      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises NUM_PORTS request handles onto one single-port SRAM with held level dones.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_port_arbiter
    import fpu_mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic [NUM_PORTS-1:0]             req_avail,
    input  logic [NUM_PORTS-1:0]             req_r_en,
    input  logic [NUM_PORTS-1:0]             req_w_en,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_ptr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             resp_done,
    output logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata,
    output logic [NUM_PORTS-1:0]             req_err,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    grant;
    logic [IDX_W-1:0]    last_grant;
    logic                lat_we;
    logic [CNT_W-1:0]    wait_cnt;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [ADDR_W-1:0]    sel_ptr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_we;

    // A held done blocks re-arbitration so a slow releaser never gets a duplicate access.
    assign eligible = req_avail & (req_r_en | req_w_en) & ~resp_done;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick_onehot),
        .grant_idx  (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_ptr   = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_onehot[i]) begin
                sel_ptr   = sel_ptr | req_ptr[i];
                sel_wdata = sel_wdata | req_wdata[i];
                sel_we    = sel_we | req_w_en[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            resp_done  <= '0;
            resp_rdata <= '0;
            req_err    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!req_avail[i]) begin
                    resp_done[i] <= 1'b0;
                end
                if (req_avail[i] && req_r_en[i] && req_w_en[i]) begin
                    req_err[i] <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_idx;
                        lat_we    <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_ptr;
                        mem_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == CNT_W'(MEM_LAT - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    // A requester that dropped avail has aborted: the access happened, no done.
                    if (req_avail[grant]) begin
                        resp_done[grant] <= 1'b1;
                        if (!lat_we) begin
                            resp_rdata[grant] <= mem_rdata;
                        end
                    end
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a one-cycle-latency SRAM model.
module tb_mem_port_arbiter;
    import fpu_mem_pkg::*;

    localparam int unsigned NP  = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic [NP-1:0]         req_avail, req_r_en, req_w_en;
    logic [NP-1:0][AW-1:0] req_ptr;
    logic [NP-1:0][DW-1:0] req_wdata;
    logic [NP-1:0]         resp_done, req_err;
    logic [NP-1:0][DW-1:0] resp_rdata;
    logic                  mem_en, mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata, mem_rdata;

    typedef struct { int port; logic [DW-1:0] data; bit rd; } exp_t;
    typedef struct { int port; logic [DW-1:0] data; int cyc; } done_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int cyc; } iss_t;

    exp_t  exp_q[$];
    done_t done_q[$];
    iss_t  iss_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stray_we = 0;
    logic [NP-1:0] prev_done = '0;

    logic [DW-1:0] sram [256];
    logic          pre_we = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        if (mem_en) begin
            if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[7:0]];
        end
    end

    mem_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .req_avail  (req_avail),
        .req_r_en   (req_r_en),
        .req_w_en   (req_w_en),
        .req_ptr    (req_ptr),
        .req_wdata  (req_wdata),
        .resp_done  (resp_done),
        .resp_rdata (resp_rdata),
        .req_err    (req_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Advance one clock and record what the DUT shows at the following falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (mem_en) iss_q.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata, cyc: cyc});
        if (mem_we && !mem_en) stray_we++;
        for (int i = 0; i < NP; i++) begin
            if (resp_done[i] && !prev_done[i])
                done_q.push_back('{port: i, data: resp_rdata[i], cyc: cyc});
            prev_done[i] = resp_done[i];
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic clear_logs();
        exp_q.delete(); done_q.delete(); iss_q.delete();
    endtask

    task automatic release_all();
        req_avail = '0; req_r_en = '0; req_w_en = '0;
        step();
    endtask

    task automatic test_reset();
        step(); step();
        n_checks++; if (resp_done !== '0) $display("FAIL reset_done: got %h want 0", resp_done); else n_pass++;
        n_checks++; if (req_err !== '0) $display("FAIL reset_err: got %h want 0", req_err); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (resp_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_contention();
        int t0;
        exp_t e;
        done_t d;
        for (int i = 0; i < NP; i++) preload(8'(8'h30 + i), 32'hA000_0000 + 32'(i));
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < NP; i++) begin
            req_ptr[i] = 32'h30 + 32'(i); req_r_en[i] = 1'b1; req_avail[i] = 1'b1;
            exp_q.push_back('{port: i, data: 32'hA000_0000 + 32'(i), rd: 1'b1});
        end
        for (int k = 0; k < 60 && resp_done !== 4'hF; k++) step();
        n_checks++; if (resp_done !== 4'hF) $display("FAIL contention_timeout: got %h want f", resp_done); else n_pass++;
        n_checks++; if (iss_q.size() != 4) $display("FAIL contention_issues: got %0d want 4", iss_q.size()); else n_pass++;
        if (done_q.size() == 4) begin
            n_checks++;
            if (done_q[0].cyc != t0 + 4) $display("FAIL contention_first_lat: got %0d want %0d", done_q[0].cyc, t0 + 4);
            else n_pass++;
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (done_q[k].cyc - done_q[k-1].cyc != LAT + 3)
                    $display("FAIL contention_spacing: got %0d want %0d", done_q[k].cyc - done_q[k-1].cyc, LAT + 3);
                else n_pass++;
            end
        end
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL contention_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || d.data !== e.data)
                    $display("FAIL contention_order: got port %0d data %h want port %0d data %h", d.port, d.data, e.port, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL contention_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
        n_checks++; if (resp_done !== '0) $display("FAIL contention_release: got %h want 0", resp_done); else n_pass++;
    endtask

    task automatic test_single_read();
        int t0;
        exp_t e;
        done_t d;
        preload(8'h10, 32'h3F80_0000);
        clear_logs();
        t0 = cyc;
        req_ptr[PORT_C] = 32'h10; req_r_en[PORT_C] = 1'b1; req_avail[PORT_C] = 1'b1;
        exp_q.push_back('{port: PORT_C, data: 32'h3F80_0000, rd: 1'b1});
        for (int k = 0; k < 20 && resp_done[PORT_C] !== 1'b1; k++) step();
        n_checks++; if (resp_done[PORT_C] !== 1'b1) $display("FAIL single_timeout: got 0 want 1"); else n_pass++;
        n_checks++; if (iss_q.size() != 1) $display("FAIL single_issues: got %0d want 1", iss_q.size()); else n_pass++;
        if (iss_q.size() >= 1) begin
            n_checks++; if (iss_q[0].addr !== 32'h10) $display("FAIL single_addr: got %h want 10", iss_q[0].addr); else n_pass++;
            n_checks++; if (iss_q[0].we !== 1'b0) $display("FAIL single_we: got %b want 0", iss_q[0].we); else n_pass++;
            n_checks++; if (iss_q[0].cyc != t0 + 1) $display("FAIL single_issue_cyc: got %0d want %0d", iss_q[0].cyc, t0 + 1); else n_pass++;
        end
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL single_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || d.data !== e.data || d.cyc != t0 + 4)
                    $display("FAIL single_done: got port %0d data %h cyc %0d want port %0d data %h cyc %0d",
                             d.port, d.data, d.cyc, e.port, e.data, t0 + 4);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL single_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (resp_done[PORT_C] !== 1'b1) $display("FAIL single_hold: got 0 want 1"); else n_pass++;
        n_checks++; if (iss_q.size() != 1) $display("FAIL single_dup: got %0d issues want 1", iss_q.size()); else n_pass++;
        req_avail[PORT_C] = 1'b0;
        #1;
        n_checks++; if (resp_done[PORT_C] !== 1'b1) $display("FAIL single_done_reg: got 0 want 1"); else n_pass++;
        step();
        n_checks++; if (resp_done[PORT_C] !== 1'b0) $display("FAIL single_clear: got 1 want 0"); else n_pass++;
        n_checks++; if (resp_rdata[PORT_C] !== 32'h3F80_0000) $display("FAIL single_rdata_hold: got %h want 3f800000", resp_rdata[PORT_C]); else n_pass++;
        release_all();
    endtask

    // Ports 0, 1, 3 together after port 2 was served last.
    task automatic test_round_robin();
        int ord [3];
        exp_t e;
        done_t d;
`ifdef MEM_ARB_FIXED_PRIO_EN
        ord = '{0, 1, 3};
`else
        ord = '{3, 0, 1};
`endif
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            req_ptr[ord[k]] = 32'h30 + 32'(ord[k]); req_r_en[ord[k]] = 1'b1; req_avail[ord[k]] = 1'b1;
            exp_q.push_back('{port: ord[k], data: 32'hA000_0000 + 32'(ord[k]), rd: 1'b1});
        end
        for (int k = 0; k < 40 && (resp_done & 4'b1011) !== 4'b1011; k++) step();
        n_checks++; if ((resp_done & 4'b1011) !== 4'b1011) $display("FAIL rr_timeout: got %h want b", resp_done); else n_pass++;
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rr_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || d.data !== e.data)
                    $display("FAIL rr_order: got port %0d data %h want port %0d data %h", d.port, d.data, e.port, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rr_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
    endtask

    task automatic test_gather();
        int ord [3];
        exp_t e;
        done_t d;
`ifdef MEM_ARB_FIXED_PRIO_EN
        ord = '{1, 2, 3};
`else
        ord = '{2, 3, 1};
`endif
        for (int i = 1; i < NP; i++) preload(8'(8'h40 + i), 32'hC0DE_0000 + 32'(i));
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            req_ptr[ord[k]] = 32'h40 + 32'(ord[k]); req_r_en[ord[k]] = 1'b1; req_avail[ord[k]] = 1'b1;
            exp_q.push_back('{port: ord[k], data: 32'hC0DE_0000 + 32'(ord[k]), rd: 1'b1});
        end
        for (int k = 0; k < 40 && (resp_done & 4'b1110) !== 4'b1110; k++) step();
        for (int k = 0; k < 5; k++) step();
        n_checks++; if (resp_done !== 4'b1110) $display("FAIL gather_held: got %h want e", resp_done); else n_pass++;
        n_checks++; if (iss_q.size() != 3) $display("FAIL gather_issues: got %0d want 3", iss_q.size()); else n_pass++;
        for (int i = 1; i < NP; i++) begin
            n_checks++;
            if (resp_rdata[i] !== 32'hC0DE_0000 + 32'(i))
                $display("FAIL gather_stable: got %h want %h", resp_rdata[i], 32'hC0DE_0000 + 32'(i));
            else n_pass++;
        end
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL gather_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || d.data !== e.data)
                    $display("FAIL gather_order: got port %0d data %h want port %0d data %h", d.port, d.data, e.port, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL gather_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
    endtask

    task automatic test_write_read();
        exp_t e;
        done_t d;
        clear_logs();
        req_ptr[PORT_D] = 32'h20; req_wdata[PORT_D] = 32'h4000_0000;
        req_w_en[PORT_D] = 1'b1; req_avail[PORT_D] = 1'b1;
        exp_q.push_back('{port: PORT_D, data: '0, rd: 1'b0});
        for (int k = 0; k < 20 && resp_done[PORT_D] !== 1'b1; k++) step();
        n_checks++; if (iss_q.size() != 1) $display("FAIL wr_issues: got %0d want 1", iss_q.size()); else n_pass++;
        if (iss_q.size() >= 1) begin
            n_checks++;
            if (iss_q[0].we !== 1'b1 || iss_q[0].addr !== 32'h20 || iss_q[0].wdata !== 32'h4000_0000)
                $display("FAIL wr_issue: got we %b addr %h data %h want we 1 addr 20 data 40000000",
                         iss_q[0].we, iss_q[0].addr, iss_q[0].wdata);
            else n_pass++;
        end
        n_checks++; if (sram[8'h20] !== 32'h4000_0000) $display("FAIL wr_sram: got %h want 40000000", sram[8'h20]); else n_pass++;
        release_all();
        req_r_en[PORT_D] = 1'b1; req_avail[PORT_D] = 1'b1;
        exp_q.push_back('{port: PORT_D, data: 32'h4000_0000, rd: 1'b1});
        for (int k = 0; k < 20 && resp_done[PORT_D] !== 1'b1; k++) step();
        n_checks++; if (iss_q.size() != 2) $display("FAIL rd_issues: got %0d want 2", iss_q.size()); else n_pass++;
        if (iss_q.size() >= 2) begin
            n_checks++; if (iss_q[1].we !== 1'b0) $display("FAIL rd_we: got %b want 0", iss_q[1].we); else n_pass++;
        end
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL wr_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || (e.rd && d.data !== e.data))
                    $display("FAIL wr_rd_done: got port %0d data %h want port %0d data %h", d.port, d.data, e.port, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL wr_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
        n_checks++; if (stray_we != 0) $display("FAIL we_outside_issue: got %0d want 0", stray_we); else n_pass++;
    endtask

    task automatic test_abort_error();
        exp_t e;
        done_t d;
        clear_logs();
        req_ptr[PORT_A] = 32'h50; req_r_en[PORT_A] = 1'b1; req_avail[PORT_A] = 1'b1;
        step(); step();
        req_avail[PORT_A] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        n_checks++; if (iss_q.size() != 1) $display("FAIL abort_issues: got %0d want 1", iss_q.size()); else n_pass++;
        n_checks++; if (done_q.size() != 0) $display("FAIL abort_done: got %0d dones want 0", done_q.size()); else n_pass++;
        n_checks++; if (resp_done[PORT_A] !== 1'b0) $display("FAIL abort_level: got 1 want 0"); else n_pass++;
        release_all();
        clear_logs();
        req_ptr[PORT_B] = 32'h60; req_wdata[PORT_B] = 32'h1234_5678;
        req_r_en[PORT_B] = 1'b1; req_w_en[PORT_B] = 1'b1; req_avail[PORT_B] = 1'b1;
        exp_q.push_back('{port: PORT_B, data: '0, rd: 1'b0});
        for (int k = 0; k < 20 && resp_done[PORT_B] !== 1'b1; k++) step();
        n_checks++; if (req_err !== 4'b0010) $display("FAIL err_flag: got %h want 2", req_err); else n_pass++;
        if (iss_q.size() >= 1) begin
            n_checks++; if (iss_q[0].we !== 1'b1) $display("FAIL err_as_write: got we %b want 1", iss_q[0].we); else n_pass++;
        end
        n_checks++; if (sram[8'h60] !== 32'h1234_5678) $display("FAIL err_sram: got %h want 12345678", sram[8'h60]); else n_pass++;
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL err_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port) $display("FAIL err_done: got port %0d want port %0d", d.port, e.port);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL err_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
        step();
        n_checks++; if (req_err !== 4'b0010) $display("FAIL err_sticky: got %h want 2", req_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        done_t d;
        clear_logs();
        req_ptr[PORT_C] = 32'h10; req_r_en[PORT_C] = 1'b1; req_avail[PORT_C] = 1'b1;
        step(); step();
        #2 rst_l = 1'b0;
        #1;
        n_checks++; if (resp_done !== '0 || req_err !== '0) $display("FAIL rstmid_flags: got done %h err %h want 0 0", resp_done, req_err); else n_pass++;
        n_checks++; if (mem_en !== 1'b0 || mem_addr !== '0) $display("FAIL rstmid_mem: got en %b addr %h want 0 0", mem_en, mem_addr); else n_pass++;
        n_checks++; if (resp_rdata !== '0) $display("FAIL rstmid_rdata: got %h want 0", resp_rdata); else n_pass++;
        req_avail = '0; req_r_en = '0; req_w_en = '0;
        step(); step();
        rst_l = 1'b1;
        step();
        clear_logs();
        req_ptr[PORT_A] = 32'h30; req_r_en[PORT_A] = 1'b1; req_avail[PORT_A] = 1'b1;
        req_ptr[PORT_C] = 32'h10; req_r_en[PORT_C] = 1'b1; req_avail[PORT_C] = 1'b1;
        exp_q.push_back('{port: PORT_A, data: 32'hA000_0000, rd: 1'b1});
        exp_q.push_back('{port: PORT_C, data: 32'h3F80_0000, rd: 1'b1});
        for (int k = 0; k < 30 && (resp_done & 4'b0101) !== 4'b0101; k++) step();
        if (iss_q.size() >= 1) begin
            n_checks++; if (iss_q[0].addr !== 32'h30) $display("FAIL rstmid_first: got addr %h want 30", iss_q[0].addr); else n_pass++;
        end
        while (done_q.size() != 0) begin
            d = done_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rstmid_extra: got done port %0d want none", d.port);
            else begin
                e = exp_q.pop_front();
                if (d.port !== e.port || d.data !== e.data)
                    $display("FAIL rstmid_order: got port %0d data %h want port %0d data %h", d.port, d.data, e.port, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rstmid_missing: got %0d left want 0", exp_q.size()); else n_pass++;
        release_all();
    endtask

    initial begin
        req_avail = '0; req_r_en = '0; req_w_en = '0; req_ptr = '0; req_wdata = '0;
        test_reset();
        test_contention();
        test_single_read();
        test_round_robin();
        test_gather();
        test_write_read();
        test_abort_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
